// File: rtl/ascon_inv_permutation_pkg.sv
// rtl/ascon_inv_permutation_pkg.sv - Ascon S-box tables, rotation amounts, round constants, FSM states and linear-layer helpers
package ascon_inv_permutation_pkg;

    typedef enum logic [1:0] {IDLE, LIN, SUB, DONE} state_e;

    // Forward S-box, listed from entry 31 down to entry 0
    localparam logic [31:0][4:0] SBOX = {
        5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
        5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
        5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
        5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
    };

    function automatic logic [31:0][4:0] invert_sbox(input logic [31:0][4:0] s);
        logic [31:0][4:0] r;
        r = '0;
        for (int v = 0; v < 32; v++) r[s[v]] = 5'(v);
        return r;
    endfunction

    localparam logic [31:0][4:0] INV_SBOX = invert_sbox(SBOX);

    localparam logic [5:0] ROT_A [5] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
    localparam logic [5:0] ROT_B [5] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

    localparam logic [3:0] FIRST_INV_ROUND = 4'd11;
    localparam logic [3:0] MAX_ROUNDS      = 4'd12;

    function automatic logic [7:0] round_const(input logic [3:0] i);
        return {4'hF - i, i};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] n);
        logic [127:0] t;
        t = {x, x} >> n;
        return t[63:0];
    endfunction

    // One factor (1 + r^(2^k*a) + r^(2^k*b)); the product over k = 0..5 is sigma^63 = sigma^-1
    function automatic logic [63:0] inv_lin_factor(input logic [63:0] x, input logic [5:0] a,
                                                   input logic [5:0] b, input logic [2:0] k);
        logic [5:0] ra;
        logic [5:0] rb;
        ra = a << k;
        rb = b << k;
        return x ^ ror64(x, ra) ^ ror64(x, rb);
    endfunction

    function automatic logic [63:0] inv_lin_full(input logic [63:0] x, input logic [5:0] a,
                                                 input logic [5:0] b);
        logic [63:0] t;
        t = x;
        for (int k = 0; k < 6; k++) t = inv_lin_factor(t, a, b, 3'(k));
        return t;
    endfunction

endpackage

// File: rtl/ascon_inv_sbox.sv
// rtl/ascon_inv_sbox.sv - 5-bit inverse Ascon S-box lookup for one bit slice
module ascon_inv_sbox
    import ascon_inv_permutation_pkg::*;
(
    input  logic [4:0] in_i,
    output logic [4:0] out_o
);

    assign out_o = INV_SBOX[in_i];

endmodule

// File: rtl/ascon_inv_permutation.sv
// rtl/ascon_inv_permutation.sv - inverse Ascon p^a, LIN/SUB pass per round; ASCON_INV_LIN_UNROLL_EN folds LIN into one cycle
module ascon_inv_permutation (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  rounds,
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    input  logic [63:0] x2,
    input  logic [63:0] x3,
    input  logic [63:0] x4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] y0,
    output logic [63:0] y1,
    output logic [63:0] y2,
    output logic [63:0] y3,
    output logic [63:0] y4,
    output logic        busy
);
    import ascon_inv_permutation_pkg::*;

    state_e      state_q, state_d;
    logic [63:0] s_q [5];
    logic [63:0] s_d [5];
    logic [63:0] lin_s [5];
    logic [63:0] sb0, sb1, sb2, sb3, sb4;
    logic [3:0]  rnd_q, stop_q;
    logic [3:0]  rounds_clamped;
    logic        accept, lin_last, sub_last;

    assign rounds_clamped = (rounds > MAX_ROUNDS) ? MAX_ROUNDS : rounds;
    assign accept         = in_valid && in_ready;
    assign sub_last       = (rnd_q == stop_q);

`ifdef ASCON_INV_LIN_UNROLL_EN
    assign lin_last = 1'b1;

    always_comb begin
        for (int w = 0; w < 5; w++) lin_s[w] = inv_lin_full(s_q[w], ROT_A[w], ROT_B[w]);
    end
`else
    logic [2:0] k_q;

    assign lin_last = (k_q == 3'd5);

    always_ff @(posedge clk) begin
        if (rst || state_q != LIN || lin_last) k_q <= '0;
        else                                   k_q <= k_q + 3'd1;
    end

    always_comb begin
        for (int w = 0; w < 5; w++) lin_s[w] = inv_lin_factor(s_q[w], ROT_A[w], ROT_B[w], k_q);
    end
`endif

    for (genvar j = 0; j < 64; j++) begin : g_sbox
        logic [4:0] slice_out;
        ascon_inv_sbox u_sbox (
            .in_i  ({s_q[0][j], s_q[1][j], s_q[2][j], s_q[3][j], s_q[4][j]}),
            .out_o (slice_out)
        );
        assign {sb0[j], sb1[j], sb2[j], sb3[j], sb4[j]} = slice_out;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (rounds_clamped == 4'd0) ? DONE : LIN;
            LIN:     if (lin_last) state_d = SUB;
            SUB:     state_d = sub_last ? DONE : LIN;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    always_comb begin
        for (int w = 0; w < 5; w++) s_d[w] = s_q[w];
        case (state_q)
            IDLE: if (accept) begin
                s_d[0] = x0;
                s_d[1] = x1;
                s_d[2] = x2;
                s_d[3] = x3;
                s_d[4] = x4;
            end
            LIN: for (int w = 0; w < 5; w++) s_d[w] = lin_s[w];
            SUB: begin
                s_d[0] = sb0;
                s_d[1] = sb1;
                s_d[2] = sb2 ^ {56'd0, round_const(rnd_q)};
                s_d[3] = sb3;
                s_d[4] = sb4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < 5; w++) s_q[w] <= '0;
            rnd_q  <= '0;
            stop_q <= '0;
        end else begin
            for (int w = 0; w < 5; w++) s_q[w] <= s_d[w];
            if (state_q == IDLE && accept) begin
                rnd_q  <= FIRST_INV_ROUND;
                stop_q <= MAX_ROUNDS - rounds_clamped;
            end else if (state_q == SUB && !sub_last) begin
                rnd_q <= rnd_q - 4'd1;
            end
        end
    end

    assign y0 = s_q[0];
    assign y1 = s_q[1];
    assign y2 = s_q[2];
    assign y3 = s_q[3];
    assign y4 = s_q[4];

endmodule

// File: tb/tb_ascon_inv_permutation.sv
// tb/tb_ascon_inv_permutation.sv - self-checking bench for ascon_inv_permutation against a forward Ascon reference
module tb_ascon_inv_permutation;

    typedef logic [4:0][63:0] state_t;

`ifdef ASCON_INV_LIN_UNROLL_EN
    localparam int CPR = 2;
`else
    localparam int CPR = 7;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  rounds = 4'd0;
    logic [63:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0, x4 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] y0, y1, y2, y3, y4;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    ascon_inv_permutation dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rounds    (rounds),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .x4        (x4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .y4        (y4),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] SB [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int RA [5] = '{19, 61, 1, 10, 7};
    localparam int RB [5] = '{28, 39, 6, 17, 41};

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [63:0] sigma(input int w, input logic [63:0] v);
        return v ^ ror(v, RA[w]) ^ ror(v, RB[w]);
    endfunction

    function automatic logic [7:0] rc(input int i);
        return 8'(((15 - i) << 4) | i);
    endfunction

    function automatic state_t fwd_round(input state_t s, input int i);
        state_t t;
        s[2] = s[2] ^ {56'd0, rc(i)};
        for (int j = 0; j < 64; j++)
            {t[0][j], t[1][j], t[2][j], t[3][j], t[4][j]} = SB[{s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]}];
        for (int w = 0; w < 5; w++) t[w] = sigma(w, t[w]);
        return t;
    endfunction

    function automatic state_t fwd_perm(input state_t s, input int a);
        for (int i = 12 - a; i < 12; i++) s = fwd_round(s, i);
        return s;
    endfunction

    function automatic logic [4:0] sbox_inv(input logic [4:0] v);
        for (int k = 0; k < 32; k++) if (SB[k] == v) return 5'(k);
        return 5'd0;
    endfunction

    // sigma^64 is the identity on 64-bit words, so 63 forward applications undo one
    function automatic state_t inv_round(input state_t s, input int i);
        state_t t;
        for (int w = 0; w < 5; w++) begin
            t[w] = s[w];
            for (int n = 0; n < 63; n++) t[w] = sigma(w, t[w]);
        end
        for (int j = 0; j < 64; j++)
            {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]} = sbox_inv({t[0][j], t[1][j], t[2][j], t[3][j], t[4][j]});
        s[2] = s[2] ^ {56'd0, rc(i)};
        return s;
    endfunction

    function automatic state_t inv_perm(input state_t s, input int a);
        for (int i = 11; i >= 12 - a; i--) s = inv_round(s, i);
        return s;
    endfunction

    function automatic state_t rnd_state();
        state_t s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic do_req(input state_t x, input logic [3:0] r, input bit early,
                          output state_t y, output int lat, output bit to);
        {x4, x3, x2, x1, x0} = x;
        rounds    = r;
        in_valid  = 1'b1;
        out_ready = early;
        @(posedge clk); #1;
        in_valid = 1'b0;
        {x4, x3, x2, x1, x0} = rnd_state();
        rounds = 4'($urandom);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        to = !out_valid;
        y  = {y4, y3, y2, y1, y0};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if ({y4, y3, y2, y1, y0} !== '0) begin n_fail++; $display("FAIL reset_y got=%h exp=0", {y4, y3, y2, y1, y0}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_round1();
        state_t x, y, exp_y;
        int lat;
        bit to;
        x = '0;
        exp_y = inv_perm(x, 1);
        do_req(x, 4'd1, 1'b0, y, lat, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL zero_r1_timeout got=%b exp=0", to); end
        n_cmp++; if (y !== exp_y) begin n_fail++; $display("FAIL zero_r1_y got=%h exp=%h", y, exp_y); end
        n_cmp++; if (y[2] !== 64'hFFFF_FFFF_FFFF_FFB4) begin n_fail++; $display("FAIL zero_r1_y2 got=%h exp=ffffffffffffffb4", y[2]); end
        n_cmp++; if (y[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL zero_r1_y0 got=%h exp=ffffffffffffffff", y[0]); end
        n_cmp++; if (fwd_perm(y, 1) !== x) begin n_fail++; $display("FAIL zero_r1_roundtrip got=%h exp=0", fwd_perm(y, 1)); end
        n_cmp++; if (lat !== CPR) begin n_fail++; $display("FAIL zero_r1_latency got=%0d exp=%0d", lat, CPR); end
    endtask

    task automatic test_single_slice();
        state_t s, x, y, exp_y;
        logic [63:0] y2c;
        logic [4:0] slice;
        int lat;
        bit to;
        s = '0;
        s[1] = 64'd1;
        s[3] = 64'd1;
        s[4] = 64'd1;
        for (int w = 0; w < 5; w++) x[w] = sigma(w, s[w]);
        exp_y = inv_perm(x, 1);
        do_req(x, 4'd1, 1'b0, y, lat, to);
        y2c = y[2] ^ 64'h4B;
        slice = {y[0][0], y[1][0], y2c[0], y[3][0], y[4][0]};
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL slice_timeout got=%b exp=0", to); end
        n_cmp++; if (slice !== 5'h01) begin n_fail++; $display("FAIL slice_0b got=%h exp=01", slice); end
        n_cmp++; if (y !== exp_y) begin n_fail++; $display("FAIL slice_y got=%h exp=%h", y, exp_y); end
    endtask

    task automatic test_zero_and_clamp();
        state_t o, x, y;
        int lat;
        bit to;
        x = rnd_state();
        do_req(x, 4'd0, 1'b0, y, lat, to);
        n_cmp++; if (y !== x) begin n_fail++; $display("FAIL r0_y got=%h exp=%h", y, x); end
        n_cmp++; if (lat !== 0 || to) begin n_fail++; $display("FAIL r0_latency got=%0d exp=0", lat); end
        o = rnd_state();
        x = fwd_perm(o, 12);
        do_req(x, 4'd15, 1'b1, y, lat, to);
        n_cmp++; if (y !== o) begin n_fail++; $display("FAIL r15_y got=%h exp=%h", y, o); end
        n_cmp++; if (lat !== 12 * CPR) begin n_fail++; $display("FAIL r15_latency got=%0d exp=%0d", lat, 12 * CPR); end
    endtask

    task automatic test_backpressure();
        state_t o, x, yh;
        int guard;
        o = rnd_state();
        x = fwd_perm(o, 8);
        {x4, x3, x2, x1, x0} = x;
        rounds   = 4'd8;
        in_valid = 1'b1;
        @(posedge clk); #1;
        guard = 0;
        while (!out_valid && guard < 200) begin
            in_valid = 1'($urandom);
            {x4, x3, x2, x1, x0} = rnd_state();
            rounds = 4'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got=%b exp=1", out_valid); end
        yh = {y4, y3, y2, y1, y0};
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'($urandom);
            {x4, x3, x2, x1, x0} = rnd_state();
            @(posedge clk); #1;
            n_cmp++; if ({y4, y3, y2, y1, y0} !== yh) begin n_fail++; $display("FAIL bp_stable_%0d got=%h exp=%h", c, {y4, y3, y2, y1, y0}, yh); end
            n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_flags_%0d got=%b%b%b exp=011", c, in_ready, out_valid, busy); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (yh !== o) begin n_fail++; $display("FAIL bp_y got=%h exp=%h", yh, o); end
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release got=%b%b exp=10", in_ready, busy); end
    endtask

    task automatic test_reset_mid();
        state_t o, x, y;
        int lat, pulses;
        bit to;
        {x4, x3, x2, x1, x0} = rnd_state();
        rounds   = 4'd12;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_flags got=%b%b%b exp=100", in_ready, out_valid, busy); end
        n_cmp++; if ({y4, y3, y2, y1, y0} !== '0) begin n_fail++; $display("FAIL rmid_y got=%h exp=0", {y4, y3, y2, y1, y0}); end
        pulses = 0;
        repeat (150) begin @(posedge clk); #1; if (out_valid) pulses++; end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL rmid_pulse got=%0d exp=0", pulses); end
        o = rnd_state();
        x = fwd_perm(o, 6);
        do_req(x, 4'd6, 1'b0, y, lat, to);
        n_cmp++; if (y !== o || to) begin n_fail++; $display("FAIL rmid_after got=%h exp=%h", y, o); end
    endtask

    task automatic test_random();
        state_t o, x, y;
        int a, lat;
        bit to;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 2))
                0:       a = 6;
                1:       a = 8;
                default: a = 12;
            endcase
            o = rnd_state();
            x = fwd_perm(o, a);
            do_req(x, 4'(a), 1'($urandom), y, lat, to);
            n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL rnd_%0d_timeout got=%b exp=0", n, to); end
            n_cmp++; if (y !== o) begin n_fail++; $display("FAIL rnd_%0d_y a=%0d got=%h exp=%h", n, a, y, o); end
            n_cmp++; if (lat !== CPR * a) begin n_fail++; $display("FAIL rnd_%0d_latency got=%0d exp=%0d", n, lat, CPR * a); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_round1();
        test_single_slice();
        test_zero_and_clamp();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
